// File: rtl/i2c_reg_slave.sv
// rtl/i2c_reg_slave.sv - I2C target with an integrated 8-bit register file
//
// Purpose: lets an external MCU read ID/version/caps/switch/SPI status and
// read/write scratch and LED registers over I2C at address SLAVE_ADDR.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   scl_i        SCL pin (asynchronous)
//   sda_i        resolved SDA bus value (asynchronous)
//   sda_o        SDA drive value (0 when pulling low)
//   sda_oe       SDA output enable
//   led_out      LED register contents
//   sw_in        switch inputs (asynchronous)
//   spi_active   SPI link activity flag
//   spi_rx_byte  last byte received by the SPI link

module i2c_reg_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oe,
  output logic [7:0] led_out,
  input  logic [7:0] sw_in,
  input  logic       spi_active,
  input  logic [7:0] spi_rx_byte
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE
  } state_t;

  // [0] first sync flop, [1] synchronized value, [2] previous synchronized value
  logic [2:0] scl_q, sda_q;
  logic [7:0] sw_s1_q, sw_s2_q;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       first_q, first_d;
  logic       sda_oe_q, sda_oe_d;
  logic       sda_o_q, sda_o_d;

  logic [7:0] scratch0_q, scratch1_q, led_q;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte, rd_cur, rd_nxt;
  logic       wr_en;

  assign scl_rise  =  scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] &  scl_q[2];
  assign start_det =  scl_q[1] &  scl_q[2] &  sda_q[2] & ~sda_q[1];
  assign stop_det  =  scl_q[1] &  scl_q[2] & ~sda_q[2] &  sda_q[1];

  assign rx_byte = {shift_q[6:0], sda_q[1]};

  function automatic logic [7:0] rd_reg(input logic [7:0] addr);
    case (addr)
      8'h00:   rd_reg = 8'hA7;
      8'h01:   rd_reg = 8'h01;
      8'h02:   rd_reg = 8'h00;
      8'h05:   rd_reg = scratch0_q;
      8'h06:   rd_reg = scratch1_q;
      8'h10:   rd_reg = 8'h95;
      8'h20:   rd_reg = led_q;
      8'h22:   rd_reg = sw_s2_q;
      8'h23:   rd_reg = {7'b0, spi_active};
      8'h24:   rd_reg = spi_rx_byte;
      default: rd_reg = 8'h00;
    endcase
  endfunction

  assign rd_cur = rd_reg(ptr_q);
  assign rd_nxt = rd_reg(ptr_q + 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q   <= 3'b111;
      sda_q   <= 3'b111;
      sw_s1_q <= 8'h00;
      sw_s2_q <= 8'h00;
    end else begin
      scl_q   <= {scl_q[1:0], scl_i};
      sda_q   <= {sda_q[1:0], sda_i};
      sw_s1_q <= sw_in;
      sw_s2_q <= sw_s1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'h00;
      ptr_q     <= 8'h00;
      first_q   <= 1'b0;
      sda_oe_q  <= 1'b0;
      sda_o_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      first_q   <= first_d;
      sda_oe_q  <= sda_oe_d;
      sda_o_q   <= sda_o_d;
    end
  end

  // Writes to read-only or unmapped addresses fall through the case silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch0_q <= 8'h00;
      scratch1_q <= 8'h00;
      led_q      <= 8'h00;
    end else if (wr_en) begin
      case (ptr_q)
        8'h05:   scratch0_q <= rx_byte;
        8'h06:   scratch1_q <= rx_byte;
        8'h20:   led_q      <= rx_byte;
        default: ;
      endcase
    end
  end

  // In the ACK states bit_cnt_q is a flag: 1 once the 9th rising edge is seen,
  // so the falling edge that follows ends the ACK slot.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    first_d   = first_q;
    sda_oe_d  = sda_oe_q;
    sda_o_d   = sda_o_q;
    wr_en     = 1'b0;

    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      sda_o_d   = 1'b1;
    end else if (stop_det) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      sda_o_d   = 1'b1;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            if (shift_q[7:1] == SLAVE_ADDR) begin
              state_d  = ADDR_ACK;
              sda_oe_d = 1'b1;
              sda_o_d  = 1'b0;
            end else begin
              state_d  = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_rise) begin
            bit_cnt_d = 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            bit_cnt_d = 4'd0;
            if (shift_q[0]) begin
              state_d  = TX;
              shift_d  = rd_cur;
              sda_oe_d = 1'b1;
              sda_o_d  = rd_cur[7];
            end else begin
              state_d  = RX;
              first_d  = 1'b1;
              sda_oe_d = 1'b0;
              sda_o_d  = 1'b1;
            end
          end
        end
        RX: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (first_q) begin
                ptr_d   = rx_byte;
                first_d = 1'b0;
              end else begin
                wr_en   = 1'b1;
                ptr_d   = ptr_q + 8'd1;
              end
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            state_d   = RX_ACK;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b1;
            sda_o_d   = 1'b0;
          end
        end
        RX_ACK: begin
          if (scl_rise) begin
            bit_cnt_d = 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            state_d   = RX;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            sda_o_d   = 1'b1;
          end
        end
        TX: begin
          // Bit 7 is already on the bus on entry; each fall drives the next bit,
          // and the eighth fall hands the bus back for the master's ACK.
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              state_d   = TX_ACK;
              bit_cnt_d = 4'd0;
              sda_oe_d  = 1'b0;
              sda_o_d   = 1'b1;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_o_d   = shift_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        TX_ACK: begin
          if (scl_rise && bit_cnt_q == 4'd0) begin
            ptr_d = ptr_q + 8'd1;
            if (!sda_q[1]) begin
              shift_d   = rd_nxt;
              bit_cnt_d = 4'd1;
            end else begin
              state_d   = IGNORE;
            end
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            state_d   = TX;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b1;
            sda_o_d   = shift_q[7];
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe  = sda_oe_q;
  assign sda_o   = sda_o_q;
  assign led_out = led_q;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// tb/tb_i2c_reg_slave.sv - directed bench for i2c_reg_slave
`timescale 1ns/1ps

module tb_i2c_reg_slave;

  localparam int Q = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [7:0] sw_in = 8'h00;
  logic       spi_active = 1'b0;
  logic [7:0] spi_rx_byte = 8'h00;
  logic       sda_o, sda_oe;
  logic [7:0] led_out;
  logic       sda_bus;

  int n_vec = 0;
  int n_err = 0;

  logic mon_en = 1'b0;
  logic pulled = 1'b0;

  assign sda_bus = m_sda & ~(sda_oe & ~sda_o);

  i2c_reg_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scl_i       (m_scl),
    .sda_i       (sda_bus),
    .sda_o       (sda_o),
    .sda_oe      (sda_oe),
    .led_out     (led_out),
    .sw_in       (sw_in),
    .spi_active  (spi_active),
    .spi_rx_byte (spi_rx_byte)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mon_en && sda_oe && !sda_o) pulled <= 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b0; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b1; #Q;
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; #Q;
      m_scl = 1'b1; #(2*Q);
      m_scl = 1'b0; #Q;
    end
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    ack = sda_bus; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] b);
    m_sda = 1'b1;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #Q; m_scl = 1'b1;
      #Q; b = {b[6:0], sda_bus};
      #Q; m_scl = 1'b0;
    end
    m_sda = nack; #Q;
    m_scl = 1'b1; #(2*Q);
    m_scl = 1'b0; #Q;
  endtask

  task automatic reg_read(input logic [7:0] ptr, output logic [7:0] d, output logic [2:0] acks);
    i2c_start();
    wr_byte(8'hA0, acks[2]);
    wr_byte(ptr, acks[1]);
    i2c_start();
    wr_byte(8'hA1, acks[0]);
    rd_byte(1'b1, d);
    i2c_stop();
  endtask

  task automatic reg_write(input logic [7:0] ptr, input logic [7:0] data, output logic [2:0] acks);
    i2c_start();
    wr_byte(8'hA0, acks[2]);
    wr_byte(ptr, acks[1]);
    wr_byte(data, acks[0]);
    i2c_stop();
  endtask

  logic [7:0] d, d2;
  logic [2:0] acks;
  logic       ack;

  initial begin
    #23;
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_sda_o", sda_o, 1'b1);
    check("rst_led", led_out, 8'h00);
    rst_n = 1'b1;
    #100;

    reg_read(8'h00, d, acks);
    check("rd_id", d, 8'hA7);
    check("rd_id_acks", acks, 3'b000);
    reg_read(8'h01, d, acks);
    check("rd_vmaj", d, 8'h01);
    check("rd_vmaj_acks", acks, 3'b000);
    reg_read(8'h02, d, acks);
    check("rd_vmin", d, 8'h00);
    reg_read(8'h10, d, acks);
    check("rd_caps", d, 8'h95);

    reg_write(8'h05, 8'h55, acks);
    check("wr_s0_acks", acks, 3'b000);
    reg_read(8'h05, d, acks);
    check("rd_s0_55", d, 8'h55);
    reg_write(8'h05, 8'hAA, acks);
    reg_read(8'h05, d, acks);
    check("rd_s0_aa", d, 8'hAA);
    reg_write(8'h06, 8'h12, acks);
    reg_read(8'h06, d, acks);
    check("rd_s1_12", d, 8'h12);
    reg_read(8'h05, d, acks);
    check("rd_s0_keep", d, 8'hAA);

    reg_write(8'h10, 8'h00, acks);
    check("wr_ro_acks", acks, 3'b000);
    reg_read(8'h10, d, acks);
    check("rd_caps_ro", d, 8'h95);

    reg_write(8'h20, 8'hF0, acks);
    #100;
    check("led_out", led_out, 8'hF0);
    reg_read(8'h20, d, acks);
    check("rd_led", d, 8'hF0);

    sw_in = 8'h3C;
    #100;
    reg_read(8'h22, d, acks);
    check("rd_sw", d, 8'h3C);
    spi_active = 1'b1;
    spi_rx_byte = 8'h5A;
    reg_read(8'h23, d, acks);
    check("rd_spi_stat", d, 8'h01);
    reg_read(8'h24, d, acks);
    check("rd_spi_rx", d, 8'h5A);

    i2c_start();
    mon_en = 1'b1;
    wr_byte(8'hA2, ack);
    mon_en = 1'b0;
    check("bad_addr_nack", ack, 1'b1);
    check("bad_addr_no_pull", pulled, 1'b0);
    i2c_stop();
    reg_read(8'h00, d, acks);
    check("rd_id_after_nack", d, 8'hA7);

    reg_write(8'h05, 8'h11, acks);
    i2c_start();
    wr_byte(8'hA0, acks[2]);
    wr_byte(8'h05, acks[1]);
    wr_byte(8'h11, acks[0]);
    wr_byte(8'h22, ack);
    i2c_stop();
    check("multi_wr_acks", {acks, ack}, 4'b0000);
    reg_read(8'h05, d, acks);
    check("multi_s0", d, 8'h11);
    reg_read(8'h06, d, acks);
    check("multi_s1", d, 8'h22);

    i2c_start();
    wr_byte(8'hA0, acks[2]);
    wr_byte(8'h05, acks[1]);
    i2c_start();
    wr_byte(8'hA1, acks[0]);
    rd_byte(1'b0, d);
    rd_byte(1'b1, d2);
    i2c_stop();
    check("burst_b0", d, 8'h11);
    check("burst_b1", d2, 8'h22);

    i2c_start();
    wr_byte(8'hA0, acks[2]);
    wr_byte(8'h00, acks[1]);
    i2c_start();
    wr_byte(8'hA1, acks[0]);
    check("mid_read_oe", sda_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_oe", sda_oe, 1'b0);
    check("rst_mid_o", sda_o, 1'b1);
    check("rst_mid_led", led_out, 8'h00);
    #50;
    rst_n = 1'b1;
    i2c_stop();
    reg_read(8'h05, d, acks);
    check("rst_s0_clear", d, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_reg_slave.md
Name: i2c_reg_slave

Overview:
- I2C target (slave) with an integrated 8-bit register file. It gives an external MCU control and status access to the FPGA: ID/version, scratch, link capabilities, LEDs, switches and SPI status.
- Sits between the board I2C pins (open-drain pad logic is external) and the board LED, switch and SPI-status nets.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit I2C address this block responds to.

Ports:
- clk  in  1  system clock, 100 MHz nominal.
- rst_n  in  1  asynchronous active-low reset.
- scl_i  in  1  SCL pin input, asynchronous.
- sda_i  in  1  SDA bus input, asynchronous (resolved bus value).
- sda_o  out  1  SDA drive value; 0 whenever pulling low.
- sda_oe  out  1  SDA output enable; bus is pulled low when sda_oe=1 and sda_o=0.
- led_out  out  8  LED register contents.
- sw_in  in  8  switch inputs, asynchronous.
- spi_active  in  1  SPI link activity flag.
- spi_rx_byte  in  8  last byte received by the SPI link.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Inputs: scl_i, sda_i and sw_in each pass through a 2-flop synchronizer. SCL and SDA edges are detected on the synchronized signals.
- Reset values: sda_oe=0, sda_o=1, led_out=0x00, scratch registers=0x00, register pointer=0x00, FSM=IDLE.
- Bus events:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are recognised in every state.
  - START (including a repeated START) aborts any transfer, releases SDA and enters ADDR.
  - STOP releases SDA and enters IDLE.
- Bit timing:
  - The slave samples SDA on the synchronized SCL rising edge.
  - It changes sda_o/sda_oe only after a synchronized SCL falling edge, within 4 clk of it.
- FSM states: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE.
  - ADDR: shift in 8 bits, MSB first.
    - If bits[7:1]==SLAVE_ADDR → ADDR_ACK.
    - Otherwise → IGNORE. No ACK is driven; the slave waits for the next START/STOP.
  - ADDR_ACK: drive SDA low (oe=1, o=0) for the 9th clock, from the falling edge after bit 8 to the falling edge after the 9th clock.
    - R/W=0 → RX, with the first RX byte flagged as the pointer byte.
    - R/W=1 → TX. Load the shift register with reg[pointer] and drive bit 7 on the falling edge that ends the ACK.
  - RX: shift in 8 bits.
    - First byte after address+W loads the pointer.
    - Each later byte writes reg[pointer], then the pointer increments (8-bit wrap, 0xFF→0x00).
    - The write commits within 3 clk of the 8th SCL rising edge, i.e. before the ACK.
    - → RX_ACK.
  - RX_ACK: drive ACK exactly as in ADDR_ACK, then return to RX. Every byte is ACKed, including writes to read-only or unmapped addresses.
  - TX: sda_oe=1 and sda_o=current bit for 8 bits; the next bit is shifted on each falling edge. After the 8th bit's falling edge, release SDA (oe=0) → TX_ACK.
  - TX_ACK: sample master ACK on the 9th rising edge.
    - ACK (0): pointer increments and reg[pointer] is loaded. TX resumes on the falling edge.
    - NACK (1): pointer increments, SDA stays released → IGNORE.
- Register map (reads of unmapped addresses return 0x00; writes to RO or unmapped addresses are ignored):
  - 0x00 DEVICE_ID, RO, 0xA7.
  - 0x01 VERSION_MAJ, RO, 0x01.
  - 0x02 VERSION_MIN, RO, 0x00.
  - 0x05 SCRATCH0, RW.
  - 0x06 SCRATCH1, RW.
  - 0x10 LINK_CAPS, RO, 0x95.
  - 0x20 LED_OUT, RW; drives led_out directly.
  - 0x22 SW_IN, RO; synchronized sw_in.
  - 0x23 SPI_STATUS, RO, {7'b0, spi_active}.
  - 0x24 SPI_RX, RO, spi_rx_byte.
- The read value is captured into the TX shift register when the byte starts; later register changes do not alter a byte in flight.
- The pointer persists across transactions and is changed only by a pointer byte or by auto-increment.
- Reset asserted mid-transfer: immediate return to reset values and SDA released.

Test Plan:
- Pointer write 0x00, repeated START, address+R, read 1 byte with NACK → 0xA7; address, pointer and read-address bytes all ACKed. Same sequence at 0x01 → 0x01, at 0x02 → 0x00, at 0x10 → 0x95.
- Write 0x05←0x55, read back → 0x55. Write 0x05←0xAA → 0xAA. Write 0x06←0x12 → 0x12; SCRATCH0 is still 0xAA.
- Write 0x20←0xF0 → led_out==0xF0 within 100 ns after STOP; read 0x20 → 0xF0.
- sw_in=0x3C, wait 100 ns, read 0x22 → 0x3C. With spi_active=1 and spi_rx_byte=0x5A: read 0x23 → 0x01, read 0x24 → 0x5A.
- Address 7'h51+W → SDA is never pulled low during the 9th clock (NACK). Then STOP and a normal read of 0x00 → 0xA7.
- Multi-byte: write pointer 0x05 followed by data 0x11, 0x22 → SCRATCH0=0x11, SCRATCH1=0x22. A burst read from 0x05 with ACK then NACK → 0x11, 0x22. Asserting rst_n low mid-read releases SDA immediately.
